// File: rtl/avalon_length_limiter_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if
// Avalon-ST style stream bundle used by avalon_length_limiter.
//
// Parameter
//   DATA_WIDTH_IN_BYTES : bytes per beat (data is 8*DATA_WIDTH_IN_BYTES bits)
//
// Signals
//   data  : beat payload, byte 0 in the most-significant byte
//   valid : source has a beat
//   rdy   : sink accepts a beat this cycle
//   sop   : first beat of a message
//   eop   : last beat of a message
//   empty : number of unused (lowest-order) bytes on an eop beat
//
// Modports
//   master : drives data/valid/sop/eop/empty, receives rdy
//   slave  : receives data/valid/sop/eop/empty, drives rdy
// -----------------------------------------------------------------------------
interface avalon_st_if #(
   parameter int DATA_WIDTH_IN_BYTES = 8
);
   localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

   logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
   logic                             valid;
   logic                             rdy;
   logic                             sop;
   logic                             eop;
   logic [EMPTY_W-1:0]               empty;

   modport master (output data, output valid, output sop, output eop, output empty,
                   input  rdy);
   modport slave  (input  data, input  valid, input  sop, input  eop, input  empty,
                   output rdy);
endinterface

// File: rtl/avalon_length_limiter.sv
// -----------------------------------------------------------------------------
// avalon_length_limiter
// Truncates Avalon-ST messages that exceed MAX_MSG_BYTES. The truncated beat is
// emitted with eop=1 and a recomputed empty, the rest of the oversize message
// is swallowed, and too_long_indi pulses once. Beats that arrive outside a
// message (no sop) are dropped. Output is a single registered stage.
//
// Parameters
//   DATA_WIDTH_IN_BYTES : bytes per beat on both streams
//   MAX_MSG_BYTES       : maximum message length, 1..65535
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   msg_in         : input stream (slave), assumed sop/eop clean
//   msg_out        : length-limited output stream (master)
//   too_long_indi  : one-cycle pulse when a truncated eop beat first appears
//   msg_len        : byte count of the message ending on the current eop beat
//   msg_len_valid  : one-cycle pulse with each output eop beat
//
// Optional feature
//   AVALON_LIMITER_LEN_REPORT_EN : when defined, adds msg_len / msg_len_valid
// -----------------------------------------------------------------------------
module avalon_length_limiter #(
   parameter int DATA_WIDTH_IN_BYTES = 8,
   parameter int MAX_MSG_BYTES       = 1518
) (
   input  logic              clk,
   input  logic              rst,
   avalon_st_if.slave        msg_in,
   avalon_st_if.master       msg_out,
`ifdef AVALON_LIMITER_LEN_REPORT_EN
   output logic [15:0]       msg_len,
   output logic              msg_len_valid,
`endif
   output logic              too_long_indi
);

   localparam int DW      = DATA_WIDTH_IN_BYTES;
   localparam int DATA_W  = 8 * DW;
   localparam int EMPTY_W = (DW > 1) ? $clog2(DW) : 1;
   // Counter must hold a full message plus one more beat without wrapping.
   localparam int CNT_W   = $clog2(MAX_MSG_BYTES + DW + 1);

   typedef enum logic [1:0] {
      BETWEEN_MSG = 2'd0,
      IN_MSG      = 2'd1,
      DROPPING    = 2'd2
   } state_t;

   // Zero the lowest-order 'e' bytes of a beat.
   function automatic logic [DATA_W-1:0] mask_empty(input logic [DATA_W-1:0] d,
                                                    input logic [EMPTY_W-1:0] e);
      logic [DATA_W-1:0] r;
      r = d;
      for (int j = 0; j < DW; j++) begin
         if (j < int'(e)) begin
            r[8*j +: 8] = 8'h00;
         end
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                out_valid_q, out_valid_d;
   logic                out_sop_q, out_sop_d;
   logic                out_eop_q, out_eop_d;
   logic [EMPTY_W-1:0]  out_empty_q, out_empty_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                too_long_q, too_long_d;

`ifdef AVALON_LIMITER_LEN_REPORT_EN
   logic [15:0]         len_q, len_d;
   logic                len_vld_q, len_vld_d;
`endif

   logic                out_free;
   logic                in_rdy;
   logic                accept;
   logic                forward;
   logic                trunc;
   logic [CNT_W-1:0]    beat_bytes;
   logic [CNT_W-1:0]    base;
   logic [CNT_W-1:0]    sum;
   logic [CNT_W-1:0]    room;
   logic [EMPTY_W-1:0]  trunc_empty;

   // Output register can take a new beat when it is empty or being drained.
   assign out_free = !out_valid_q || msg_out.rdy;
   // While dropping nothing is written to the output register, so the input
   // can be drained at full rate regardless of downstream backpressure.
   assign in_rdy   = (state_q == DROPPING) || out_free;
   assign accept   = msg_in.valid && in_rdy;

   assign beat_bytes = msg_in.eop ? (CNT_W'(DW) - CNT_W'(msg_in.empty)) : CNT_W'(DW);
   // A new message restarts the count, so the first beat sees a base of 0.
   assign base       = (state_q == IN_MSG) ? cnt_q : '0;
   assign sum        = base + beat_bytes;

   assign forward = accept &&
                    (((state_q == BETWEEN_MSG) && msg_in.sop) || (state_q == IN_MSG));

   // Reaching exactly the limit without eop also truncates: the next beat
   // would necessarily exceed it.
   assign trunc = (sum > CNT_W'(MAX_MSG_BYTES)) ||
                  ((sum == CNT_W'(MAX_MSG_BYTES)) && !msg_in.eop);

   // base is always below the limit here, so room is 1..DW on a truncation.
   assign room        = CNT_W'(MAX_MSG_BYTES) - base;
   assign trunc_empty = EMPTY_W'(CNT_W'(DW) - room);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_free ? 1'b0 : out_valid_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_empty_d = out_empty_q;
      out_data_d  = out_data_q;
      too_long_d  = 1'b0;
`ifdef AVALON_LIMITER_LEN_REPORT_EN
      len_d       = len_q;
      len_vld_d   = 1'b0;
`endif

      if (forward) begin
         out_valid_d = 1'b1;
         out_sop_d   = (state_q == BETWEEN_MSG);
         if (trunc) begin
            out_eop_d   = 1'b1;
            out_empty_d = trunc_empty;
            cnt_d       = CNT_W'(MAX_MSG_BYTES);
            too_long_d  = 1'b1;
            state_d     = msg_in.eop ? BETWEEN_MSG : DROPPING;
         end else begin
            out_eop_d   = msg_in.eop;
            out_empty_d = msg_in.eop ? msg_in.empty : '0;
            cnt_d       = sum;
            state_d     = msg_in.eop ? BETWEEN_MSG : IN_MSG;
         end
         out_data_d = mask_empty(msg_in.data, out_empty_d);
`ifdef AVALON_LIMITER_LEN_REPORT_EN
         if (out_eop_d) begin
            len_vld_d = 1'b1;
            len_d     = trunc ? 16'(MAX_MSG_BYTES) : 16'(sum);
         end
`endif
      end else if (accept && (state_q == DROPPING) && msg_in.eop) begin
         state_d = BETWEEN_MSG;
         cnt_d   = '0;
      end
   end

   // ---- output register stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BETWEEN_MSG;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_empty_q <= '0;
         out_data_q  <= '0;
         too_long_q  <= 1'b0;
`ifdef AVALON_LIMITER_LEN_REPORT_EN
         len_q       <= '0;
         len_vld_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_empty_q <= out_empty_d;
         out_data_q  <= out_data_d;
         too_long_q  <= too_long_d;
`ifdef AVALON_LIMITER_LEN_REPORT_EN
         len_q       <= len_d;
         len_vld_q   <= len_vld_d;
`endif
      end
   end

   assign msg_in.rdy    = in_rdy;
   assign msg_out.valid = out_valid_q;
   assign msg_out.sop   = out_sop_q;
   assign msg_out.eop   = out_eop_q;
   assign msg_out.empty = out_empty_q;
   assign msg_out.data  = out_data_q;
   assign too_long_indi = too_long_q;
`ifdef AVALON_LIMITER_LEN_REPORT_EN
   assign msg_len       = len_q;
   assign msg_len_valid = len_vld_q;
`endif

endmodule

// File: tb/tb_avalon_length_limiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_length_limiter
// Scoreboard bench: DUT A (4 bytes/beat, max 10 bytes) and DUT B (4 bytes/beat,
// max 8 bytes). Stimulus pushes hand-computed expected output beats into a
// per-DUT queue; monitors pop and compare on every output handshake.
// -----------------------------------------------------------------------------
module tb_avalon_length_limiter;

   typedef struct {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic        tl;
      logic [15:0] len;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) a_in ();
   avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) a_out ();
   avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) b_in ();
   avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) b_out ();

   logic        tl_a, tl_b;
`ifdef AVALON_LIMITER_LEN_REPORT_EN
   logic [15:0] len_a, len_b;
   logic        lv_a, lv_b;
`endif

   avalon_length_limiter #(.DATA_WIDTH_IN_BYTES(4), .MAX_MSG_BYTES(10)) dut_a (
      .clk           (clk),
      .rst           (rst),
      .msg_in        (a_in),
      .msg_out       (a_out),
`ifdef AVALON_LIMITER_LEN_REPORT_EN
      .msg_len       (len_a),
      .msg_len_valid (lv_a),
`endif
      .too_long_indi (tl_a)
   );

   avalon_length_limiter #(.DATA_WIDTH_IN_BYTES(4), .MAX_MSG_BYTES(8)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .msg_in        (b_in),
      .msg_out       (b_out),
`ifdef AVALON_LIMITER_LEN_REPORT_EN
      .msg_len       (len_b),
      .msg_len_valid (lv_b),
`endif
      .too_long_indi (tl_b)
   );

   exp_t qa[$];
   exp_t qb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   pulses_a = 0;
   int   pulses_b = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic exp_t mk(input logic [31:0] d, input logic s, input logic e,
                               input logic [1:0] em, input logic tl, input logic [15:0] len);
      exp_t x;
      x.data = d; x.sop = s; x.eop = e; x.empty = em; x.tl = tl; x.len = len;
      return x;
   endfunction

   // ---------------- monitors ----------------
   logic        pend_a = 1'b0, pend_b = 1'b0;
   logic        seen_tl_a = 1'b0, seen_tl_b = 1'b0;
   logic [16:0] seen_len_a = '0, seen_len_b = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         pend_a = 1'b0;
      end else begin
         if (tl_a) pulses_a++;
         if (a_out.valid && !pend_a) begin
            seen_tl_a = tl_a;
`ifdef AVALON_LIMITER_LEN_REPORT_EN
            seen_len_a = {lv_a, len_a};
`endif
         end
         if (a_out.valid && a_out.rdy) begin
            if (qa.size() == 0) begin
               n_checks++;
               $display("FAIL A unexpected beat: got data %h, required no beat", a_out.data);
            end else begin
               e = qa.pop_front();
               chk("A beat {data,sop,eop,empty,tl}",
                   {27'd0, a_out.data, a_out.sop, a_out.eop, a_out.empty, seen_tl_a},
                   {27'd0, e.data, e.sop, e.eop, e.empty, e.tl});
`ifdef AVALON_LIMITER_LEN_REPORT_EN
               if (e.eop) chk("A msg_len", {47'd0, seen_len_a}, {47'd0, 1'b1, e.len});
`endif
            end
         end
         pend_a = a_out.valid && !a_out.rdy;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         pend_b = 1'b0;
      end else begin
         if (tl_b) pulses_b++;
         if (b_out.valid && !pend_b) begin
            seen_tl_b = tl_b;
`ifdef AVALON_LIMITER_LEN_REPORT_EN
            seen_len_b = {lv_b, len_b};
`endif
         end
         if (b_out.valid && b_out.rdy) begin
            if (qb.size() == 0) begin
               n_checks++;
               $display("FAIL B unexpected beat: got data %h, required no beat", b_out.data);
            end else begin
               e = qb.pop_front();
               chk("B beat {data,sop,eop,empty,tl}",
                   {27'd0, b_out.data, b_out.sop, b_out.eop, b_out.empty, seen_tl_b},
                   {27'd0, e.data, e.sop, e.eop, e.empty, e.tl});
`ifdef AVALON_LIMITER_LEN_REPORT_EN
               if (e.eop) chk("B msg_len", {47'd0, seen_len_b}, {47'd0, 1'b1, e.len});
`endif
            end
         end
         pend_b = b_out.valid && !b_out.rdy;
      end
   end

   // ---------------- driver ----------------
   task automatic set_beat(input int which, input logic [31:0] d, input logic s,
                           input logic e, input logic [1:0] em);
      if (which == 0) begin
         a_in.data = d; a_in.sop = s; a_in.eop = e; a_in.empty = em; a_in.valid = 1'b1;
      end else begin
         b_in.data = d; b_in.sop = s; b_in.eop = e; b_in.empty = em; b_in.valid = 1'b1;
      end
   endtask

   task automatic send_beat(input int which, input logic [31:0] d, input logic s,
                            input logic e, input logic [1:0] em);
      logic acc;
      acc = 1'b0;
      set_beat(which, d, s, e, em);
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = (which == 0) ? a_in.rdy : b_in.rdy;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_checks++;
         $display("FAIL input accept timeout: dut %0d data %h not accepted in 50 cycles", which, d);
      end
      if (which == 0) a_in.valid = 1'b0;
      else            b_in.valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      a_in.valid = 1'b0; a_in.data = '0; a_in.sop = 1'b0; a_in.eop = 1'b0; a_in.empty = '0;
      b_in.valid = 1'b0; b_in.data = '0; b_in.sop = 1'b0; b_in.eop = 1'b0; b_in.empty = '0;
      a_out.rdy  = 1'b1;
      b_out.rdy  = 1'b1;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("A reset valid",  {63'd0, a_out.valid}, 64'd0);
      chk("A reset tl",     {63'd0, tl_a},        64'd0);
      chk("A reset in.rdy", {63'd0, a_in.rdy},    64'd1);
      chk("B reset valid",  {63'd0, b_out.valid}, 64'd0);
      chk("A reset data",   {32'd0, a_out.data},  64'd0);
      @(posedge clk); #1;

      // 10-byte message exactly at the limit passes unchanged
      qa.push_back(mk(32'h11223344, 1, 0, 2'd0, 0, 16'd0));
      qa.push_back(mk(32'h55667788, 0, 0, 2'd0, 0, 16'd0));
      qa.push_back(mk(32'h99AA0000, 0, 1, 2'd2, 0, 16'd10));
      send_beat(0, 32'h11223344, 1, 0, 2'd0);
      send_beat(0, 32'h55667788, 0, 0, 2'd0);
      send_beat(0, 32'h99AA0000, 0, 1, 2'd2);

      // 16-byte message: third beat truncated to 2 bytes, fourth dropped
      qa.push_back(mk(32'hA1A2A3A4, 1, 0, 2'd0, 0, 16'd0));
      qa.push_back(mk(32'hB1B2B3B4, 0, 0, 2'd0, 0, 16'd0));
      qa.push_back(mk(32'hC1C20000, 0, 1, 2'd2, 1, 16'd10));
      send_beat(0, 32'hA1A2A3A4, 1, 0, 2'd0);
      send_beat(0, 32'hB1B2B3B4, 0, 0, 2'd0);
      send_beat(0, 32'hC1C2C3C4, 0, 0, 2'd0);
      send_beat(0, 32'hD1D2D3D4, 0, 1, 2'd0);

      // stray non-sop beat is discarded; following single-beat message passes
      send_beat(0, 32'hDEADBEEF, 0, 0, 2'd0);
      qa.push_back(mk(32'h12345600, 1, 1, 2'd1, 0, 16'd3));
      send_beat(0, 32'h12345600, 1, 1, 2'd1);

      // downstream stall for 5 cycles mid-message
      qa.push_back(mk(32'h01020304, 1, 0, 2'd0, 0, 16'd0));
      qa.push_back(mk(32'h05060708, 0, 0, 2'd0, 0, 16'd0));
      qa.push_back(mk(32'h0A000000, 0, 1, 2'd3, 0, 16'd9));
      send_beat(0, 32'h01020304, 1, 0, 2'd0);
      a_out.rdy = 1'b0;
      set_beat(0, 32'h05060708, 0, 0, 2'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("A stall in.rdy", {63'd0, a_in.rdy}, 64'd0);
         chk("A stall hold {valid,data,sop,eop,empty}",
             {28'd0, a_out.valid, a_out.data, a_out.sop, a_out.eop, a_out.empty},
             {28'd0, 1'b1, 32'h01020304, 1'b1, 1'b0, 2'd0});
      end
      @(posedge clk); #1;
      a_out.rdy = 1'b1;
      send_beat(0, 32'h05060708, 0, 0, 2'd0);
      send_beat(0, 32'h0A000000, 0, 1, 2'd3);
      repeat (3) @(posedge clk); #1;

      // reset after the first beat: in-flight beat lost, rest of message dropped
      a_out.rdy = 1'b0;
      send_beat(0, 32'h77777777, 1, 0, 2'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("A valid after reset", {63'd0, a_out.valid}, 64'd0);
      @(posedge clk); #1;
      a_out.rdy = 1'b1;
      send_beat(0, 32'h88888888, 0, 0, 2'd0);
      send_beat(0, 32'h99999999, 0, 1, 2'd0);
      qa.push_back(mk(32'h31323334, 1, 0, 2'd0, 0, 16'd0));
      qa.push_back(mk(32'h41424300, 0, 1, 2'd1, 0, 16'd7));
      send_beat(0, 32'h31323334, 1, 0, 2'd0);
      send_beat(0, 32'h41424344, 0, 1, 2'd1);

      // DUT B (max 8): limit reached without eop truncates, eop beat dropped
      qb.push_back(mk(32'hE1E2E3E4, 1, 0, 2'd0, 0, 16'd0));
      qb.push_back(mk(32'hF1F2F3F4, 0, 1, 2'd0, 1, 16'd8));
      send_beat(1, 32'hE1E2E3E4, 1, 0, 2'd0);
      send_beat(1, 32'hF1F2F3F4, 0, 0, 2'd0);
      send_beat(1, 32'h01010101, 0, 1, 2'd0);
      // single-beat message: empty bytes forced to zero
      qb.push_back(mk(32'hAA000000, 1, 1, 2'd3, 0, 16'd1));
      send_beat(1, 32'hAABBCCDD, 1, 1, 2'd3);

      for (int n = 0; n < 100 && (qa.size() != 0 || qb.size() != 0); n++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk("A queue drained", 64'(qa.size()), 64'd0);
      chk("B queue drained", 64'(qb.size()), 64'd0);
      chk("A too_long pulses", 64'(pulses_a), 64'd1);
      chk("B too_long pulses", 64'(pulses_b), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/avalon_length_limiter.md
AVALON_LENGTH_LIMITER -- requirements
Module: avalon_length_limiter

Interface
REQ-001 Parameter DATA_WIDTH_IN_BYTES, default 8, sets the number of bytes per beat on both stream ports.
REQ-002 Parameter MAX_MSG_BYTES, default 1518, sets the maximum message length in bytes; legal range 1..65535.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port msg_in, avalon_st_if.slave: an already sop/eop-clean stream with fields data, valid, rdy, sop, eop and empty (log2up(DATA_WIDTH_IN_BYTES) bits).
REQ-006 Port msg_out, avalon_st_if.master: the length-limited stream, with the same fields and widths as msg_in.
REQ-007 Port too_long_indi, output, 1 bit: pulses for one cycle when a message is truncated.

Function
REQ-008 A beat SHALL be accepted on msg_in when msg_in.valid and msg_in.rdy are both 1, and SHALL be delivered on msg_out when msg_out.valid and msg_out.rdy are both 1.
REQ-009 The output SHALL be one registered stage with 1-cycle latency, and msg_in.rdy SHALL equal (!msg_out.valid | msg_out.rdy) except in DROPPING, where it is 1.
REQ-010 While msg_out.valid=1 and msg_out.rdy=0, all msg_out fields SHALL hold stable.
REQ-011 The byte count of a beat SHALL be DATA_WIDTH_IN_BYTES minus empty on an eop beat, and DATA_WIDTH_IN_BYTES otherwise.
REQ-012 Byte 0 SHALL be the most-significant byte, and empty bytes SHALL be the lowest-order bytes.
REQ-013 The block SHALL keep a running byte counter wide enough for MAX_MSG_BYTES+DATA_WIDTH_IN_BYTES, with no wrap.
REQ-014 The state machine SHALL have exactly three states: BETWEEN_MSG, IN_MSG and DROPPING.
REQ-015 In BETWEEN_MSG, an accepted beat with sop=1 SHALL be forwarded and the counter loaded with its byte count; an accepted beat with sop=0 SHALL be discarded silently.
REQ-016 In BETWEEN_MSG, a sop=1 beat without eop SHALL move the state to IN_MSG; a sop&eop single-beat message SHALL stay in BETWEEN_MSG.
REQ-017 In IN_MSG, an accepted beat SHALL be forwarded with sop forced to 0, and the counter SHALL increase by the beat's byte count.
REQ-018 In IN_MSG, an accepted eop beat SHALL move the state to BETWEEN_MSG.
REQ-019 Truncation SHALL trigger when count+beat_bytes > MAX_MSG_BYTES, or when count+beat_bytes == MAX_MSG_BYTES with eop=0; this rule also applies to the first beat.
REQ-020 On truncation, the beat SHALL be output with eop=1 and empty=DATA_WIDTH_IN_BYTES-(MAX_MSG_BYTES-count), where count is the value before the beat.
REQ-021 On truncation, too_long_indi SHALL pulse in the cycle the truncated beat appears on msg_out.
REQ-022 On truncation, the next state SHALL be DROPPING if the input beat had eop=0, and BETWEEN_MSG otherwise.
REQ-023 In DROPPING, all accepted beats SHALL be discarded (sop included), and an accepted eop SHALL return the state to BETWEEN_MSG.
REQ-024 The empty bytes of any output eop beat SHALL be driven to 0.
REQ-025 msg_out.empty SHALL be 0 on every beat that is not an eop beat.
REQ-026 Messages of exactly MAX_MSG_BYTES ending in eop SHALL pass unmodified, with no pulse.

Reset
REQ-027 When rst=1 at a clock edge: the state SHALL become BETWEEN_MSG; the counter, msg_out.valid, sop, eop, empty, data and too_long_indi SHALL become 0; and any in-flight beat SHALL be lost.
REQ-028 A reset in mid-message SHALL cause the remaining non-sop beats of that message to be discarded according to REQ-015.

Configuration
REQ-029 With AVALON_LIMITER_LEN_REPORT_EN defined, the block SHALL add output msg_len (16 bits) and output msg_len_valid (1 bit).
REQ-030 With AVALON_LIMITER_LEN_REPORT_EN defined, msg_len_valid SHALL pulse for one cycle together with each output eop beat, and msg_len SHALL equal the output message's byte count.
REQ-031 With AVALON_LIMITER_LEN_REPORT_EN defined, msg_len and msg_len_valid SHALL reset to 0.
REQ-032 Without AVALON_LIMITER_LEN_REPORT_EN, msg_len and msg_len_valid SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DATA_WIDTH_IN_BYTES=4, MAX_MSG_BYTES=10 unless stated)
REQ-033 Input 3 beats (sop; -; eop, empty=2), msg_out.rdy=1 -> identical output 1 cycle later, no too_long_indi, and msg_len=10 when enabled.
REQ-034 Input 4 beats (16 bytes, last eop empty=0) -> 3 output beats, the third with eop=1 and empty=2 and its low 2 bytes 0; the 4th input beat accepted and dropped; one too_long_indi pulse.
REQ-035 MAX_MSG_BYTES=8; input 3 beats with eop on the 3rd -> 2 output beats, the 2nd with eop=1 and empty=0; one pulse; the 3rd beat dropped.
REQ-036 msg_out.rdy held 0 for 5 cycles mid-message -> msg_in.rdy=0 and msg_out fields stable throughout; no beat lost or duplicated afterwards.
REQ-037 Input valid beat with sop=0 in BETWEEN_MSG -> no output and no pulse; a following sop message passes normally.
REQ-038 rst=1 for one cycle after the 1st beat of a 3-beat message -> msg_out.valid=0 the next cycle; the 2 remaining beats are discarded; the next sop message passes normally.
